halt_dump_ctrl: RTL and testbench
=================================

# halt_dump_ctrl

Halt-detect and end-of-program memory-dump controller for the pipelined CPU. It watches the instruction fetched each cycle. On the halt word it freezes fetch and waits a fixed number of cycles so in-flight instructions retire. It then raises the show enable and streams every data-memory word out over a valid/ready port, so the run/drain/dump sequence is done in hardware instead of by the bench.

## Interface
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that ends the program
- DRAIN_CYCLES, 4, cycles waited after halt detection before dumping; legal range 1..255
- MEM_DEPTH, 512, number of 32-bit data-memory words dumped; must be ≥1
- ADDR_W, 9, word-address width; must satisfy 2^ADDR_W ≥ MEM_DEPTH
- CLK  in  1  single clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- instruction  in  32  instruction currently in fetch
- if_valid  in  1  instruction is a real fetch, not a bubble
- halt_stall  out  1  freeze PC/IF stage
- show_en  out  1  dump phase active (drives the CPU Show_EN)
- mem_rd_en  out  1  data-memory read strobe
- mem_rd_addr  out  ADDR_W  data-memory word address
- mem_rd_data  in  32  read data, valid the cycle after mem_rd_en
- dump_valid  out  1  dump_data/dump_addr hold a word
- dump_ready  in  1  sink accepts the word
- dump_data  out  32  dumped word
- dump_addr  out  ADDR_W  address of dumped word
- done  out  1  all MEM_DEPTH words accepted

## Operation
- States: RUN, DRAIN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE. Reset state is RUN.
- RUN
  - If if_valid && instruction==HALT_WORD: go to DRAIN, load drain counter with DRAIN_CYCLES-1.
  - Halt word with if_valid=0 is ignored.
- DRAIN
  - halt_stall=1.
  - Counter decrements each cycle; at 0, go to DUMP_RD with address=0.
  - instruction/if_valid are ignored.
- DUMP_RD
  - mem_rd_en=1, mem_rd_addr=address.
  - Next state is DUMP_CAP.
- DUMP_CAP
  - Latch mem_rd_data into dump_data and address into dump_addr.
  - Next state is DUMP_OUT.
- DUMP_OUT
  - dump_valid=1.
  - On dump_valid && dump_ready: if address==MEM_DEPTH-1, go to DONE; else address+1, go to DUMP_RD.
- DONE
  - done=1.
  - Terminal until reset; later halt words are ignored.
- halt_stall=1 in every state except RUN.
- show_en=1 in DUMP_RD, DUMP_CAP, DUMP_OUT and DONE.
- mem_rd_en=1 only in DUMP_RD.
- Address counter is ADDR_W bits and never wraps; the terminal compare is against MEM_DEPTH-1.
- dump_ready while dump_valid=0 has no effect.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- Reset (asynchronous, takes effect immediately): state=RUN, all outputs 0, address=0, counter=0. Reset mid-drain or mid-dump aborts the sequence, with no partial handshake.
- Halt seen at edge T: halt_stall=1 from T+1.
- DRAIN occupies exactly DRAIN_CYCLES cycles; show_en and the first mem_rd_en rise at T+1+DRAIN_CYCLES.
- Per word, minimum 3 cycles (RD, CAP, OUT with ready=1); each cycle of dump_ready=0 adds one.
- dump_data, dump_addr and dump_valid hold stable while dump_valid && !dump_ready.
- done rises the cycle after the final handshake.
- Last-word handshake goes to DONE; it issues no further read.

## Test plan
- HALT_WORD arrives with if_valid=0, then 0x20080001 with if_valid=1 → stays in RUN, halt_stall=0, show_en=0 throughout.
- DRAIN_CYCLES=4, halt at edge T → halt_stall=1 at T+1, show_en=1 and mem_rd_en=1 with mem_rd_addr=0 at T+5.
- MEM_DEPTH=4, memory = {0x11,0x22,0x33,0x44}, dump_ready tied 1 → four handshakes, (addr,data)=(0,0x11)…(3,0x44), 3 cycles apart; done=1 one cycle after the 4th; mem_rd_en pulses exactly 4 times.
- Random dump_ready stalls (e.g. low 3 cycles on word 2) → dump_data/dump_addr stable while stalled, no word skipped or duplicated, order 0..MEM_DEPTH-1.
- Deassert RST_N during DUMP_OUT of word 2 → outputs 0 immediately; after release, state is RUN and a new halt restarts the dump at address 0.
- Halt word re-presented in DONE → done stays 1, no further mem_rd_en.

Source files
------------

// File: rtl/halt_dump_ctrl.sv
// Halt detection and end-of-program data-memory dump controller.
// Freezes fetch on the halt word, drains the pipeline, then streams memory out over valid/ready.
module halt_dump_ctrl #(
    parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          MEM_DEPTH    = 512,
    parameter int          ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              if_valid,
    output logic              halt_stall,
    output logic              show_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              done
);

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        DONE
    } state_t;

    localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);

    state_t            state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       dump_data_reg, dump_data_next;
    logic [ADDR_W-1:0] dump_addr_reg, dump_addr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            dump_data_reg <= '0;
            dump_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            dump_data_reg <= dump_data_next;
            dump_addr_reg <= dump_addr_next;
        end
    end

    // Every output is decoded from registered state only; inputs steer next-state alone.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        dump_data_next = dump_data_reg;
        dump_addr_next = dump_addr_reg;
        halt_stall     = 1'b1;
        show_en        = 1'b0;
        mem_rd_en      = 1'b0;
        dump_valid     = 1'b0;
        done           = 1'b0;

        unique case (state_reg)
            RUN: begin
                halt_stall = 1'b0;
                if (if_valid && instruction == HALT_WORD) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_reg == 8'd0) begin
                    state_next = DUMP_RD;
                    addr_next  = '0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DUMP_RD: begin
                show_en    = 1'b1;
                mem_rd_en  = 1'b1;
                state_next = DUMP_CAP;
            end
            DUMP_CAP: begin
                show_en        = 1'b1;
                dump_data_next = mem_rd_data;
                dump_addr_next = addr_reg;
                state_next     = DUMP_OUT;
            end
            DUMP_OUT: begin
                show_en    = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (addr_reg == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = DUMP_RD;
                    end
                end
            end
            DONE: begin
                show_en = 1'b1;
                done    = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign mem_rd_addr = addr_reg;
    assign dump_data   = dump_data_reg;
    assign dump_addr   = dump_addr_reg;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Self-checking bench for halt_dump_ctrl: vector table for the run phase, directed
// drain/dump/reset/done sequences, and randomized stalls against a queue-style reference.
module tb_halt_dump_ctrl;

    localparam logic [31:0] HW = 32'hFFFFFFFF;
    localparam int DC = 4;
    localparam int MD = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instruction = '0;
    logic          if_valid = 1'b0;
    logic          halt_stall, show_en, mem_rd_en, dump_valid, done;
    logic [AW-1:0] mem_rd_addr, dump_addr;
    logic [31:0]   mem_rd_data = '0;
    logic [31:0]   dump_data;
    logic          dump_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt;
    logic [31:0] mem [0:7];

    halt_dump_ctrl #(
        .HALT_WORD(HW), .DRAIN_CYCLES(DC), .MEM_DEPTH(MD), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .if_valid(if_valid),
        .halt_stall(halt_stall), .show_en(show_en), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory: data appears the cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) rd_cnt <= 0;
        else if (mem_rd_en) rd_cnt <= rd_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instruction = '0;
        if_valid = 1'b0;
        tick();
        tick();
        chk("rst_halt_stall", halt_stall, 0);
        chk("rst_outputs", {show_en, mem_rd_en, dump_valid, done}, 0);
        chk("rst_dump_data", dump_data, 0);
        rst_n = 1'b1;
    endtask

    task automatic halt_now();
        instruction = HW;
        if_valid = 1'b1;
        tick();
        instruction = '0;
        if_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int hs;
        int last_hs;
        int c;
        int idx;
        int last_hs_cyc;
        logic pv;
        logic [31:0] pd;
        logic [AW-1:0] pa;
        logic got;
        logic [31:0] ins;
        logic vl;

        vecs[0] = '{HW,            1'b0, 1'b0};
        vecs[1] = '{32'h20080001,  1'b1, 1'b0};
        vecs[2] = '{32'h00000000,  1'b1, 1'b0};
        vecs[3] = '{HW,            1'b0, 1'b0};
        vecs[4] = '{32'hFFFFFFFE,  1'b1, 1'b0};
        vecs[5] = '{32'h7FFFFFFF,  1'b1, 1'b0};
        vecs[6] = '{HW,            1'b1, 1'b1};

        for (int i = 0; i < 8; i++) mem[i] = 32'h11 * (i + 1);

        // Run phase from the vector table, ending with a real halt.
        do_reset();
        dump_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instruction = vecs[i].instr;
            if_valid = vecs[i].vld;
            tick();
            chk($sformatf("vec%0d_halt_stall", i), halt_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_show_en", i), show_en, 0);
        end
        instruction = '0;
        if_valid = 1'b0;

        // Drain lasts exactly DC cycles after the halt edge.
        for (int k = 1; k < DC; k++) begin
            tick();
            chk("drain_show_en", show_en, 0);
            chk("drain_stall", halt_stall, 1);
        end
        tick();
        chk("first_rd_show_en", show_en, 1);
        chk("first_rd_en", mem_rd_en, 1);
        chk("first_rd_addr", mem_rd_addr, 0);

        // Full-rate dump: one handshake every 3 cycles, done one cycle after the last.
        hs = 0;
        last_hs = 0;
        got = 1'b0;
        for (int cy = 0; cy < 60; cy++) begin
            if (dump_valid && dump_ready) begin
                chk("fast_addr", dump_addr, hs);
                chk("fast_data", dump_data, 32'h11 * (hs + 1));
                if (hs > 0) chk("fast_gap", cy - last_hs, 3);
                last_hs = cy;
                hs++;
                if (hs == MD) begin
                    tick();
                    chk("fast_done", done, 1);
                    got = 1'b1;
                    break;
                end
            end
            tick();
        end
        chk("fast_completed", got, 1);
        chk("fast_rd_count", rd_cnt, MD);

        // Halt re-presented in DONE changes nothing.
        instruction = HW;
        if_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("done_hold", {done, mem_rd_en, dump_valid}, 3'b100);
        end
        chk("done_rd_count", rd_cnt, MD);
        instruction = '0;
        if_valid = 1'b0;

        // Asynchronous reset during the output phase of word 2.
        do_reset();
        halt_now();
        dump_ready = 1'b1;
        got = 1'b0;
        for (int cy = 0; cy < 60; cy++) begin
            dump_ready = !(dump_valid && dump_addr == 2);
            if (dump_valid && dump_addr == 2) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_word2", got, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {halt_stall, show_en, mem_rd_en, dump_valid, done}, 0);
        chk("async_rst_data", dump_data, 0);
        chk("async_rst_addr", {dump_addr, mem_rd_addr}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_run", {halt_stall, show_en}, 0);
        halt_now();
        dump_ready = 1'b1;
        got = 1'b0;
        for (int cy = 0; cy < 30; cy++) begin
            if (dump_valid && dump_ready) begin
                chk("restart_addr", dump_addr, 0);
                chk("restart_data", dump_data, mem[0]);
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("restart_handshake", got, 1);

        // Randomized: noisy fetch before the halt, random ready stalls during the dump.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            for (int i = 0; i < 40; i++) begin
                ins = ($urandom_range(0, 3) == 0) ? HW : $urandom;
                vl = 1'(($urandom_range(0, 2)) != 0);
                if (i == 39) begin
                    ins = HW;
                    vl = 1'b1;
                end
                instruction = ins;
                if_valid = vl;
                dump_ready = 1'(($urandom_range(0, 1)));
                tick();
                chk("rnd_run_stall", halt_stall, (vl && ins == HW));
                if (vl && ins == HW) break;
            end
            instruction = '0;
            if_valid = 1'b0;
            idx = 0;
            pv = 1'b0;
            pd = '0;
            pa = '0;
            last_hs_cyc = -1;
            c = 0;
            while (c < 400 && !done) begin
                instruction = ($urandom_range(0, 1) == 0) ? HW : $urandom;
                if_valid = 1'(($urandom_range(0, 1)));
                dump_ready = 1'(($urandom_range(0, 2) == 0));
                if (dump_valid) begin
                    if (dump_ready) begin
                        chk("rnd_order", dump_addr, idx);
                        chk("rnd_data", dump_data, mem[idx]);
                        idx++;
                        last_hs_cyc = c;
                        pv = 1'b0;
                    end else begin
                        pv = 1'b1;
                        pd = dump_data;
                        pa = dump_addr;
                    end
                end
                tick();
                c++;
                if (c < DC) chk("rnd_drain_show", show_en, 0);
                if (c == DC) chk("rnd_show_rise", {show_en, mem_rd_en}, 2'b11);
                if (pv) begin
                    chk("rnd_stall_valid", dump_valid, 1);
                    chk("rnd_stall_data", dump_data, pd);
                    chk("rnd_stall_addr", dump_addr, pa);
                    pv = 1'b0;
                end
            end
            chk("rnd_done", done, 1);
            chk("rnd_word_count", idx, MD);
            chk("rnd_done_timing", c, last_hs_cyc + 1);
            chk("rnd_rd_count", rd_cnt, MD);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
